// File: rtl/inst_sram_responder_pkg.sv
// Shared definitions for the instruction SRAM responder slice.
//   RESET_VECTOR : byte address the CPU fetches first after reset; the
//                  default address of memory word 0
//   state_t      : wait-state FSM encoding (IDLE, BUSY, RESP)
//   lane_merge   : builds the new memory word from the old word, the write
//                  data and the per-byte write strobes
package inst_sram_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = wen[k] ? wdata[8*k +: 8] : old_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/inst_sram_responder_if.sv
// Instruction SRAM bus between the fetch stage (master) and the memory
// responder (slave).
//   en       : request valid this cycle
//   wen      : byte write strobes, 0 means read
//   addr     : byte address
//   wdata    : write data
//   rdata    : response word, held until the next response
//   addr_ok  : request accepted this cycle when en is high
//   data_ok  : rdata valid this cycle (one-cycle pulse)
//   addr_err : sticky out-of-range / misaligned flag
interface inst_sram_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;
  logic        addr_err;

  modport master (
    output en, wen, addr, wdata,
    input  rdata, addr_ok, data_ok, addr_err
  );

  modport slave (
    input  en, wen, addr, wdata,
    output rdata, addr_ok, data_ok, addr_err
  );
endinterface

// File: rtl/inst_sram_array.sv
// Word array of 2^ADDR_WIDTH x 32 bits with one synchronous read-first
// port and byte-lane writes.
//   clk   : clock
//   en    : port enable; rdata updates only on enabled cycles
//   wen   : byte write strobes (ignored when en is low)
//   idx   : word index
//   wdata : write data
//   rdata : word stored at idx before this cycle's write
// Contents are never reset.
module inst_sram_array
  import inst_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            wen,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      if (|wen) begin
        mem[idx] <= lane_merge(mem[idx], wdata, wen);
      end
    end
  end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction memory responder for the fetch stage. Decodes the byte
// address against BASE_ADDR, reads/writes the word array and returns the
// addressed word (old contents on writes) one cycle after acceptance, or
// WAIT_CYCLES+1 cycles after acceptance when INST_SRAM_WAIT_EN is defined.
// Out-of-range or misaligned accesses leave memory untouched, respond with
// zero and set the sticky addr_err flag.
//   clk       : clock
//   rst       : synchronous active-high reset (memory contents kept)
//   inst_sram : inst_sram_if slave port (en, wen, addr, wdata, rdata,
//               addr_ok, data_ok, addr_err)
// Optional feature macro: INST_SRAM_WAIT_EN (wait-state FSM).
module inst_sram_responder
  import inst_sram_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_sram_if.slave   inst_sram
);

  // Byte span covered by the array: 4 bytes per word.
  localparam logic [31:0] SPAN = 32'd4 << ADDR_WIDTH;

  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  ready;
  logic                  accept;
  logic                  arr_en;
  logic [3:0]            arr_wen;
  logic [31:0]           arr_rdata;
  logic                  err;

  // Modular subtraction: addresses below BASE_ADDR wrap to huge offsets
  // and fall out of range naturally.
  assign offset   = inst_sram.addr - BASE_ADDR;
  assign in_range = (offset < SPAN) && (inst_sram.addr[1:0] == 2'b00);
  assign idx      = offset[ADDR_WIDTH+1:2];

  // rst has priority over a request in the same cycle.
  assign accept  = inst_sram.en && ready && !rst;
  assign arr_en  = accept && in_range;
  assign arr_wen = arr_en ? inst_sram.wen : 4'b0000;

  inst_sram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .wen   (arr_wen),
    .idx   (idx),
    .wdata (inst_sram.wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && !in_range) begin
      err <= 1'b1;
    end
  end

  assign inst_sram.addr_err = err;
  assign inst_sram.addr_ok  = ready;

`ifdef INST_SRAM_WAIT_EN

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        zero_p1;
  logic [31:0] rdata_q;
  logic        data_ok;

  // Requests are only taken outside BUSY; nothing is queued.
  assign ready = (state != BUSY);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt_nxt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        data_ok = 1'b1;
        // A request taken during the response cycle starts a new access.
        if (accept) begin
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      zero_p1 <= 1'b1;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        zero_p1 <= !in_range;
      end
      // Array output was captured at acceptance and is stable through BUSY;
      // publish it only as the response is presented so rdata holds the
      // previous response until then.
      if (state == BUSY && state_nxt == RESP) begin
        rdata_q <= zero_p1 ? 32'h0 : arr_rdata;
      end
    end
  end

  assign inst_sram.data_ok = data_ok;
  assign inst_sram.rdata   = rdata_q;

`else

  logic vld_p1;
  logic zero_p1;

  assign ready = 1'b1;

  // Response stage: the array register is the data pipeline register; only
  // the valid and the zero-response select are tracked here. arr_rdata
  // only moves on accepted in-range requests, so rdata holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      zero_p1 <= 1'b1;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        zero_p1 <= !in_range;
      end
    end
  end

  assign inst_sram.data_ok = vld_p1;
  assign inst_sram.rdata   = zero_p1 ? 32'h0 : arr_rdata;

`endif

endmodule

// File: tb/tb_inst_sram_responder.sv
module tb_inst_sram_responder;
  import inst_sram_pkg::*;

  localparam logic [31:0] BASE = 32'hbfc00000;
`ifdef INST_SRAM_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  inst_sram_if bus();

  inst_sram_responder dut (
    .clk       (clk),
    .rst       (rst),
    .inst_sram (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request presented for one cycle; waits (bounded) for data_ok.
  task automatic req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                     output logic [31:0] r, output int lat);
    bus.en = 1'b1; bus.wen = w; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.en = 1'b0; bus.wen = 4'h0;
    lat = 1;
    while (!bus.data_ok && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bus.rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.wen = 4'h0; bus.addr = BASE; bus.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want %h", bus.rdata, 32'h0); end
    vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL reset_data_ok got %b want 0", bus.data_ok); end
    vectors++; if (bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL reset_addr_err got %b want 0", bus.addr_err); end
    vectors++; if (bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL reset_addr_ok got %b want 1", bus.addr_ok); end
  endtask

  task automatic test_full_write();
    logic [31:0] r; int lat;
    req(BASE, 4'hF, 32'hDEADBEEF, r, lat);
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL full_write_latency got %0d want %0d", lat, LAT); end
    req(BASE, 4'h0, 32'h0, r, lat);
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL full_read_latency got %0d want %0d", lat, LAT); end
    vectors++; if (r !== 32'hDEADBEEF) begin miscompares++; $display("FAIL full_read_data got %h want %h", r, 32'hDEADBEEF); end
  endtask

  task automatic test_lane_write();
    logic [31:0] r; int lat;
    req(BASE + 4, 4'hF, 32'hAABBCCDD, r, lat);
    req(BASE + 4, 4'b0101, 32'h11223344, r, lat);
    vectors++; if (r !== 32'hAABBCCDD) begin miscompares++; $display("FAIL lane_write_old got %h want %h", r, 32'hAABBCCDD); end
    req(BASE + 4, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'hAA22CC44) begin miscompares++; $display("FAIL lane_merge got %h want %h", r, 32'hAA22CC44); end
  endtask

  task automatic test_raw();
    logic [31:0] r; int lat;
    req(BASE + 8, 4'hF, 32'h0BADF00D, r, lat);
    req(BASE + 8, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'h0BADF00D) begin miscompares++; $display("FAIL raw_read got %h want %h", r, 32'h0BADF00D); end
  endtask

  task automatic test_back_to_back();
`ifndef INST_SRAM_WAIT_EN
    bus.en = 1'b1; bus.wen = 4'h0; bus.addr = BASE;
    @(posedge clk); #1; bus.addr = BASE + 4;
    vectors++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL b2b_0 got ok=%b %h want ok=1 %h", bus.data_ok, bus.rdata, 32'hDEADBEEF); end
    @(posedge clk); #1; bus.addr = BASE + 8;
    vectors++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'hAA22CC44) begin miscompares++; $display("FAIL b2b_1 got ok=%b %h want ok=1 %h", bus.data_ok, bus.rdata, 32'hAA22CC44); end
    @(posedge clk); #1; bus.en = 1'b0;
    vectors++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL b2b_2 got ok=%b %h want ok=1 %h", bus.data_ok, bus.rdata, 32'h0BADF00D); end
    @(posedge clk); #1;
    vectors++; if (bus.data_ok !== 1'b0 || bus.rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL rdata_hold got ok=%b %h want ok=0 %h", bus.data_ok, bus.rdata, 32'h0BADF00D); end
`endif
  endtask

  task automatic test_range();
    logic [31:0] r; int lat;
    req(BASE + 32'h1000, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'h0 || bus.addr_err !== 1'b1) begin miscompares++; $display("FAIL oor_read got %h err=%b want 0 err=1", r, bus.addr_err); end
    req(BASE, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'hDEADBEEF || bus.addr_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %h err=%b want %h err=1", r, bus.addr_err, 32'hDEADBEEF); end
    req(BASE + 2, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL misaligned_read got %h want 0", r); end
    // Out-of-range write aliasing onto word 0 must not modify memory.
    req(BASE + 32'h1000, 4'hF, 32'h12345678, r, lat);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL oor_write_resp got %h want 0", r); end
    req(BASE - 4, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL below_base got %h want 0", r); end
    req(BASE, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'hDEADBEEF) begin miscompares++; $display("FAIL oor_no_alias got %h want %h", r, 32'hDEADBEEF); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    vectors++; if (bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", bus.addr_err); end
  endtask

  task automatic test_rst_wins();
    logic [31:0] r; int lat;
    rst = 1'b1; bus.en = 1'b1; bus.wen = 4'hF; bus.addr = BASE + 8; bus.wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b0; bus.en = 1'b0; bus.wen = 4'h0;
    vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_wins_ok got %b want 0", bus.data_ok); end
    req(BASE + 8, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'h0BADF00D) begin miscompares++; $display("FAIL rst_wins_mem got %h want %h", r, 32'h0BADF00D); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] r; int lat;
    bus.en = 1'b1; bus.wen = 4'hF; bus.addr = BASE + 12; bus.wdata = 32'h600DCAFE;
    @(posedge clk); #1;
    bus.en = 1'b0; bus.wen = 4'h0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (bus.addr_ok !== 1'b1 || bus.data_ok !== 1'b0 || bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mid_state got aok=%b dok=%b %h want aok=1 dok=0 0", bus.addr_ok, bus.data_ok, bus.rdata); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_mid_dropped cycle %0d got %b want 0", i, bus.data_ok); end
    end
    req(BASE + 12, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'h600DCAFE) begin miscompares++; $display("FAIL rst_mid_mem got %h want %h", r, 32'h600DCAFE); end
  endtask

  task automatic test_wait();
`ifdef INST_SRAM_WAIT_EN
    logic [31:0] r; int lat;
    req(BASE + 16, 4'hF, 32'h00000055, r, lat);
    // Cycle 10: read accepted.
    bus.en = 1'b1; bus.wen = 4'h0; bus.addr = BASE;
    vectors++; if (bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL wait_c10_aok got %b want 1", bus.addr_ok); end
    @(posedge clk); #1;
    // Cycle 11: BUSY; this write must be ignored.
    bus.wen = 4'hF; bus.addr = BASE + 16; bus.wdata = 32'h99999999;
    vectors++; if (bus.addr_ok !== 1'b0 || bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL wait_c11 got aok=%b dok=%b want 0 0", bus.addr_ok, bus.data_ok); end
    @(posedge clk); #1;
    bus.en = 1'b0; bus.wen = 4'h0;
    vectors++; if (bus.addr_ok !== 1'b0 || bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL wait_c12 got aok=%b dok=%b want 0 0", bus.addr_ok, bus.data_ok); end
    @(posedge clk); #1;
    vectors++; if (bus.data_ok !== 1'b1 || bus.addr_ok !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wait_c13 got dok=%b aok=%b %h want 1 1 %h", bus.data_ok, bus.addr_ok, bus.rdata, 32'hDEADBEEF); end
    @(posedge clk); #1;
    vectors++; if (bus.data_ok !== 1'b0 || bus.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wait_c14 got dok=%b %h want 0 %h", bus.data_ok, bus.rdata, 32'hDEADBEEF); end
    req(BASE + 16, 4'h0, 32'h0, r, lat);
    vectors++; if (r !== 32'h00000055) begin miscompares++; $display("FAIL wait_ignored_write got %h want %h", r, 32'h00000055); end
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_full_write();
    test_lane_write();
    test_raw();
    test_back_to_back();
    test_range();
    test_rst_wins();
    test_rst_mid();
    test_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
